// File: rtl/counter_seek_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_seek_arbiter
// Description : Shares one external up/down counter between two requesters.
//               A requester hands over a target through a valid/ready
//               handshake. The block then steers the counter (inc or dec)
//               until its count equals the target, and pulses done to the
//               requester that owns the seek. Ties between requesters are
//               resolved round-robin. A seek can be cancelled with abort.
//
// Ports       :
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   count        in   [W] live value from the controlled counter
//   req0_valid   in   requester 0 offers a target
//   req0_target  in   [W] requester 0 target value
//   req0_ready   out  requester 0 target accepted this cycle (comb.)
//   req0_done    out  one-cycle pulse: requester 0 seek finished
//   req1_valid   in   requester 1 offers a target
//   req1_target  in   [W] requester 1 target value
//   req1_ready   out  requester 1 target accepted this cycle (comb.)
//   req1_done    out  one-cycle pulse: requester 1 seek finished
//   abort        in   cancel the seek in progress
//   aborted      out  one-cycle pulse alongside done for a cancelled seek
//   mode         out  [2] counter control: 00 hold, 01 inc, 10 dec
//   busy         out  high while a seek is in progress or completing
//
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seek_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] count,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_target,
    output logic         req0_ready,
    output logic         req0_done,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_target,
    output logic         req1_ready,
    output logic         req1_done,
    input  logic         abort,
    output logic         aborted,
    output logic [1:0]   mode,
    output logic         busy
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] C_MODE_HOLD = 2'b00;
    localparam logic [1:0] C_MODE_INC  = 2'b01;
    localparam logic [1:0] C_MODE_DEC  = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [W-1:0]   r_target;
    logic           r_owner;       // requester that owns the current seek
    logic           r_last_grant;  // requester granted most recently
    logic           r_done0;
    logic           r_done1;
    logic           r_aborted;
    logic           r_busy;

    logic           w_idle;
    logic           w_grant0;
    logic           w_grant1;
    logic           w_at_target;
    logic [1:0]     w_mode;

    // ------------------------------------------------------------------
    // Arbitration: grants only in IDLE. On a tie the requester that did
    // not win last time is served, so the two grants are mutually
    // exclusive by construction.
    // ------------------------------------------------------------------
    assign w_idle   = (r_state == ST_IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

    assign w_at_target = (count == r_target);

    // ------------------------------------------------------------------
    // Counter steering. Direction comes from an unsigned compare, not the
    // shortest wrap path. Because the decode uses the live count, mode is
    // already HOLD in the very cycle count reaches the target, so the
    // counter never overshoots.
    // ------------------------------------------------------------------
    always_comb begin
        w_mode = C_MODE_HOLD;
        if (r_state == ST_SEEK) begin
            if (count < r_target) begin
                w_mode = C_MODE_INC;
            end else if (count > r_target) begin
                w_mode = C_MODE_DEC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_target     <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;      // requester 0 wins the first tie
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_aborted    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // done and aborted are single-cycle pulses
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_aborted <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant0) begin
                        r_target     <= req0_target;
                        r_owner      <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SEEK;
                    end else if (w_grant1) begin
                        r_target     <= req1_target;
                        r_owner      <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SEEK;
                    end
                end

                ST_SEEK: begin
                    // Abort wins over arrival; either way the owner is told
                    // the seek has ended, and aborted says which kind.
                    if (abort || w_at_target) begin
                        r_done0   <= ~r_owner;
                        r_done1   <= r_owner;
                        r_aborted <= abort;
                        r_state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // One dead cycle: no grant can be issued here.
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign req0_done  = r_done0;
    assign req1_done  = r_done1;
    assign aborted    = r_aborted;
    assign mode       = w_mode;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_counter_seek_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seek_arbiter
// Description : Directed bench for counter_seek_arbiter. Models the external
//               up/down counter (with a load port for setting start values)
//               and checks handshake, steering, latency, arbitration, abort
//               and asynchronous reset behaviour against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seek_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] count = 8'd0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_target = 8'd0;
    logic       req0_ready;
    logic       req0_done;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_target = 8'd0;
    logic       req1_ready;
    logic       req1_done;
    logic       abort = 1'b0;
    logic       aborted;
    logic [1:0] mode;
    logic       busy;

    logic       ld = 1'b0;
    logic [7:0] ld_val = 8'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_seek_arbiter #(.W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .req0_valid  (req0_valid),
        .req0_target (req0_target),
        .req0_ready  (req0_ready),
        .req0_done   (req0_done),
        .req1_valid  (req1_valid),
        .req1_target (req1_target),
        .req1_ready  (req1_ready),
        .req1_done   (req1_done),
        .abort       (abort),
        .aborted     (aborted),
        .mode        (mode),
        .busy        (busy)
    );

    // External counter model driven by mode, with a bench-side load.
    always @(posedge clk) begin
        if (ld)                  count <= ld_val;
        else if (mode == 2'b01)  count <= count + 8'd1;
        else if (mode == 2'b10)  count <= count - 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        ld = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld = 1'b0;
        #1;
    endtask

    // One complete uncontested seek with undisturbed counter.
    task automatic seek(input int r, input logic [7:0] tgt, input logic [1:0] dir,
                        input int d, input logic [7:0] fin);
        if (r == 0) begin req0_valid = 1'b1; req0_target = tgt; end
        else        begin req1_valid = 1'b1; req1_target = tgt; end
        #1;
        chk("ready_req",   (r == 0) ? req0_ready : req1_ready, 1);
        chk("ready_other", (r == 0) ? req1_ready : req0_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("seek_busy", busy, 1);
        chk("seek_ready", {req0_ready, req1_ready}, 0);
        for (int i = 0; i < d; i++) begin
            chk("seek_mode", mode, dir);
            chk("seek_no_done", {req0_done, req1_done}, 0);
            @(negedge clk);
            #1;
        end
        chk("equal_mode", mode, 0);
        chk("equal_count", count, fin);
        chk("equal_no_done", {req0_done, req1_done}, 0);
        @(negedge clk);
        #1;
        chk("done_owner", (r == 0) ? req0_done : req1_done, 1);
        chk("done_other", (r == 0) ? req1_done : req0_done, 0);
        chk("done_aborted", aborted, 0);
        chk("done_mode", mode, 0);
        chk("done_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("idle_done", {req0_done, req1_done}, 0);
        chk("idle_busy", busy, 0);
        chk("idle_count", count, fin);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        chk("rst_mode", mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_done", {req0_done, req1_done}, 0);
        chk("rst_aborted", aborted, 0);
        reset = 1'b0;

        // Increment 10 -> 14 and decrement 20 -> 17
        load(8'd10);
        seek(0, 8'd14, 2'b01, 4, 8'd14);
        load(8'd20);
        seek(1, 8'd17, 2'b10, 3, 8'd17);
        @(negedge clk);
        #1;
        chk("hold_17", count, 17);

        // Zero distance
        load(8'd5);
        seek(1, 8'd5, 2'b00, 0, 8'd5);

        // Round-robin ties starting from reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load(8'd5);
        req0_valid = 1'b1; req0_target = 8'd5;
        req1_valid = 1'b1; req1_target = 8'd5;
        #1;
        chk("tie1_ready0", req0_ready, 1);
        chk("tie1_ready1", req1_ready, 0);
        @(negedge clk); #1;
        chk("tie1_seek_ready", {req0_ready, req1_ready}, 0);
        chk("tie1_seek_mode", mode, 0);
        @(negedge clk); #1;
        chk("tie1_done", {req0_done, req1_done}, 2'b10);
        chk("tie1_done_ready", {req0_ready, req1_ready}, 0);
        @(negedge clk); #1;
        chk("tie2_ready", {req0_ready, req1_ready}, 2'b01);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("tie2_done", {req0_done, req1_done}, 2'b01);
        @(negedge clk); #1;
        chk("tie3_ready", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("tie3_withdrawn_busy", busy, 0);

        // Abort at the third SEEK cycle of 0 -> 200
        load(8'd0);
        req0_valid = 1'b1; req0_target = 8'd200;
        #1;
        chk("abt_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("abt_c1_mode", mode, 1);
        @(negedge clk); #1;
        chk("abt_c2_count", count, 1);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abt_c3_count", count, 2);
        chk("abt_c3_mode", mode, 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abt_done", {req0_done, req1_done}, 2'b10);
        chk("abt_aborted", aborted, 1);
        chk("abt_mode", mode, 0);
        chk("abt_count", count, 3);
        @(negedge clk); #1;
        chk("abt_after", {req0_done, aborted, busy}, 0);
        chk("abt_after_count", count, 3);
        seek(1, 8'd5, 2'b01, 2, 8'd5);

        // Unsigned direction, no wrap shortcut
        load(8'd250);
        seek(0, 8'd3, 2'b10, 247, 8'd3);

        // Reset in the middle of 50 -> 100
        load(8'd50);
        req0_valid = 1'b1; req0_target = 8'd100;
        #1;
        chk("rs_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("rs_count60", count, 60);
        chk("rs_mode_pre", mode, 1);
        reset = 1'b1;
        #1;
        chk("rs_mode_async", mode, 0);
        chk("rs_busy_async", busy, 0);
        @(negedge clk); #1;
        chk("rs_no_done", {req0_done, req1_done, aborted}, 0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rs_rel_no_done", {req0_done, req1_done, busy}, 0);
        chk("rs_count_held", count, 60);
        seek(1, 8'd58, 2'b10, 2, 8'd58);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
